// File: rtl/riscv_pkg.sv
// Shared RV32 definitions for the front end: opcode constants, the fetch buffer
// entry layout and the word-alignment helper.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage signal bundle: instruction memory port, redirect port and decode
// handshake. The master modport is the fetch unit's view.
interface fetch_unit_if;
  import riscv_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            id_valid;
  logic            id_ready;
  logic [XLEN-1:0] id_instr;
  logic [XLEN-1:0] id_pc;
  logic [6:0]      id_opcode;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata,
    input  redirect_valid, redirect_pc,
    output id_valid, id_instr, id_pc, id_opcode,
    input  id_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata,
    output redirect_valid, redirect_pc,
    input  id_valid, id_instr, id_pc, id_opcode,
    output id_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush and occupancy count; the head word is
// presented directly from storage so a registered entry is visible the cycle after push.
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_empty,
  output logic [AW:0]      o_count
);

  localparam logic [AW:0] DEPTH_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  // Flush dominates; a pop frees the slot a simultaneous push lands in.
  assign w_do_pop  = i_pop && !i_flush && (r_count != '0);
  assign w_do_push = i_push && !i_flush && ((r_count != DEPTH_CNT) || w_do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_do_push) begin
      r_mem[r_wptr] <= i_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_data  = r_mem[r_rptr];
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word fetches, buffers responses
// and hands them to decode; redirects discard every younger in-flight response.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter int              BUF_DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_unit_if.master  bus
);

  localparam int            CW        = $clog2(BUF_DEPTH);
  localparam int            EW        = $bits(fetch_entry_t);
  localparam logic [CW+1:0] DEPTH_OCC = (CW+2)'(BUF_DEPTH);

  logic [XLEN-1:0] r_fetch_pc;
  logic [CW:0]     r_drop_cnt;

  logic [CW:0]     w_outstanding;
  logic [CW:0]     w_instr_count;
  logic            w_addr_empty;
  logic            w_instr_empty;
  logic [XLEN-1:0] w_rsp_pc;
  logic [EW-1:0]   w_head_bits;
  fetch_entry_t    w_head;
  fetch_entry_t    w_push_entry;
  logic            w_pop;
  logic [CW+1:0]   w_occ;
  logic            w_req;
  logic            w_grant;
  logic            w_rvalid;
  logic            w_keep_rsp;

  // In-flight plus buffered work, net of the entry decode takes this cycle,
  // bounds issue so every returning response is guaranteed a buffer slot.
  assign w_pop      = !w_instr_empty && bus.id_ready;
  assign w_occ      = {1'b0, w_outstanding} + {1'b0, w_instr_count}
                      - {{(CW+1){1'b0}}, w_pop};
  assign w_req      = rst_n && !bus.redirect_valid && (w_occ < DEPTH_OCC);
  assign w_grant    = w_req && bus.imem_gnt;
  assign w_rvalid   = bus.imem_rvalid && !w_addr_empty;
  assign w_keep_rsp = w_rvalid && (r_drop_cnt == '0) && !bus.redirect_valid;

  assign w_push_entry = '{pc: w_rsp_pc, instr: bus.imem_rdata};
  assign w_head       = fetch_entry_t'(w_head_bits);

  // The address FIFO's occupancy doubles as the outstanding-request count.
  fetch_fifo #(
    .WIDTH (XLEN),
    .DEPTH (BUF_DEPTH)
  ) u_addr_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (1'b0),
    .i_push  (w_grant),
    .i_data  (r_fetch_pc),
    .i_pop   (w_rvalid),
    .o_data  (w_rsp_pc),
    .o_empty (w_addr_empty),
    .o_count (w_outstanding)
  );

  fetch_fifo #(
    .WIDTH (EW),
    .DEPTH (BUF_DEPTH)
  ) u_instr_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (bus.redirect_valid),
    .i_push  (w_keep_rsp),
    .i_data  (w_push_entry),
    .i_pop   (w_pop),
    .o_data  (w_head_bits),
    .o_empty (w_instr_empty),
    .o_count (w_instr_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc <= RESET_PC;
    end else if (bus.redirect_valid) begin
      r_fetch_pc <= word_align(bus.redirect_pc);
    end else if (w_grant) begin
      r_fetch_pc <= r_fetch_pc + 32'd4;
    end
  end

  // On redirect, every response still owed after this cycle is stale.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop_cnt <= '0;
    end else if (bus.redirect_valid) begin
      r_drop_cnt <= w_outstanding - {{CW{1'b0}}, w_rvalid};
    end else if (w_rvalid && (r_drop_cnt != '0)) begin
      r_drop_cnt <= r_drop_cnt - 1'b1;
    end
  end

  assign bus.imem_req  = w_req;
  assign bus.imem_addr = r_fetch_pc;
  assign bus.id_valid  = !w_instr_empty;
  assign bus.id_instr  = w_head.instr;
  assign bus.id_pc     = w_head.pc;
  assign bus.id_opcode = w_head.instr[6:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an in-order instruction memory model of
// configurable latency and optional random grant stalls.
module tb_fetch_unit;
  import riscv_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  fetch_unit_if bus();

  fetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .BUF_DEPTH (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int lat = 1;
  bit gnt_rand = 1'b0;
  int grant_cnt = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;
  mreq_t mq[$];

  function automatic logic [31:0] word(input logic [31:0] a);
    logic [6:0] opc;
    case (a[4:2])
      3'd0: opc = OPC_RTYPE;
      3'd1: opc = OPC_STORE;
      3'd2: opc = OPC_BRANCH;
      3'd3: opc = OPC_LUI;
      3'd4: opc = OPC_JAL;
      3'd5: opc = OPC_LOAD;
      3'd6: opc = OPC_OPIMM;
      default: opc = NOP_INSTR[6:0];
    endcase
    return {a[26:2], opc};
  endfunction

  // Memory: samples request/grant at the edge, drives outputs 1 time unit later.
  initial begin
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        mq.delete();
      end else if (bus.imem_req && bus.imem_gnt) begin
        mq.push_back('{addr: bus.imem_addr, due: cyc + lat});
        grant_cnt++;
      end
      cyc++;
      #1;
      if (rst_n && mq.size() > 0 && mq[0].due <= cyc) begin
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = word(mq[0].addr);
        void'(mq.pop_front());
      end else begin
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;
      end
      bus.imem_gnt = gnt_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  end

  // Leaves the bench 1 time unit into cycle 0 after reset release.
  task automatic restart(input int l, input bit r, input logic rdy);
    @(negedge clk);
    rst_n = 1'b0;
    bus.id_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    gnt_rand = r;
    lat = l;
    repeat (3) @(negedge clk);
    grant_cnt = 0;
    bus.id_ready = rdy;
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", bus.imem_req); end
    checks++; if (bus.id_valid !== 1'b0) begin errors++; $display("FAIL reset_id_valid: got %b expected 0", bus.id_valid); end
    checks++; if (bus.id_instr !== 32'h0) begin errors++; $display("FAIL reset_id_instr: got %h expected 0", bus.id_instr); end
    checks++; if (bus.id_pc !== 32'h0) begin errors++; $display("FAIL reset_id_pc: got %h expected 0", bus.id_pc); end
    checks++; if (bus.id_opcode !== 7'h0) begin errors++; $display("FAIL reset_id_opcode: got %h expected 0", bus.id_opcode); end
    checks++; if (bus.imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h expected 0", bus.imem_addr); end
    $display("reset: req=%b id_valid=%b addr=%h", bus.imem_req, bus.id_valid, bus.imem_addr);
  endtask

  task automatic test_stream();
    logic [31:0] exp_pc;
    logic [31:0] exp_w;
    restart(1, 1'b0, 1'b1);
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin errors++; $display("FAIL stream_first_req: got req=%b addr=%h expected req=1 addr=0", bus.imem_req, bus.imem_addr); end
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'(4 * c)) begin errors++; $display("FAIL stream_addr c%0d: got req=%b addr=%h expected req=1 addr=%h", c, bus.imem_req, bus.imem_addr, 32'(4 * c)); end
      checks++; if (bus.id_valid !== (c >= 2)) begin errors++; $display("FAIL stream_valid c%0d: got %b expected %b", c, bus.id_valid, (c >= 2)); end
      if (c >= 2) begin
        exp_pc = 32'(4 * (c - 2));
        exp_w  = word(exp_pc);
        checks++; if (bus.id_pc !== exp_pc) begin errors++; $display("FAIL stream_pc c%0d: got %h expected %h", c, bus.id_pc, exp_pc); end
        checks++; if (bus.id_instr !== exp_w) begin errors++; $display("FAIL stream_instr c%0d: got %h expected %h", c, bus.id_instr, exp_w); end
        checks++; if (bus.id_opcode !== exp_w[6:0]) begin errors++; $display("FAIL stream_opcode c%0d: got %h expected %h", c, bus.id_opcode, exp_w[6:0]); end
        $display("stream: cycle %0d id_pc=%h id_instr=%h", c, bus.id_pc, bus.id_instr);
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] exp_w;
    restart(1, 1'b0, 1'b0);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      checks++; if (bus.imem_req !== (c == 1)) begin errors++; $display("FAIL stall_req c%0d: got %b expected %b", c, bus.imem_req, (c == 1)); end
      if (c >= 2) begin
        checks++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'h0) begin errors++; $display("FAIL stall_hold c%0d: got valid=%b pc=%h expected valid=1 pc=0", c, bus.id_valid, bus.id_pc); end
      end
    end
    checks++; if (grant_cnt !== 2) begin errors++; $display("FAIL stall_grants: got %0d expected 2", grant_cnt); end
    @(negedge clk);
    bus.id_ready = 1'b1;
    #1;
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h8) begin errors++; $display("FAIL stall_release_req: got req=%b addr=%h expected req=1 addr=8", bus.imem_req, bus.imem_addr); end
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      exp_w = word(32'(4 * k));
      checks++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'(4 * k) || bus.id_instr !== exp_w) begin errors++; $display("FAIL stall_order %0d: got valid=%b pc=%h instr=%h expected pc=%h instr=%h", k, bus.id_valid, bus.id_pc, bus.id_instr, 32'(4 * k), exp_w); end
      $display("stall: delivered id_pc=%h", bus.id_pc);
    end
  endtask

  task automatic test_redirect();
    logic [31:0] exp_w;
    restart(2, 1'b0, 1'b1);
    @(negedge clk);
    checks++; if (bus.id_valid !== 1'b0) begin errors++; $display("FAIL redir_c1_valid: got %b expected 0", bus.id_valid); end
    @(negedge clk);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h0000_0100;
    #1;
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL redir_req_low: got %b expected 0", bus.imem_req); end
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    #1;
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h100) begin errors++; $display("FAIL redir_new_req: got req=%b addr=%h expected req=1 addr=100", bus.imem_req, bus.imem_addr); end
    checks++; if (bus.id_valid !== 1'b0) begin errors++; $display("FAIL redir_r1_valid: got %b expected 0", bus.id_valid); end
    for (int c = 4; c <= 5; c++) begin
      @(negedge clk);
      checks++; if (bus.id_valid !== 1'b0) begin errors++; $display("FAIL redir_stale c%0d: got valid=1 pc=%h expected valid=0", c, bus.id_pc); end
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      exp_w = word(32'h100 + 32'(4 * k));
      checks++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'h100 + 32'(4 * k) || bus.id_instr !== exp_w) begin errors++; $display("FAIL redir_deliver %0d: got valid=%b pc=%h instr=%h expected pc=%h instr=%h", k, bus.id_valid, bus.id_pc, bus.id_instr, 32'h100 + 32'(4 * k), exp_w); end
      $display("redirect: delivered id_pc=%h", bus.id_pc);
    end
  endtask

  task automatic test_misaligned();
    restart(1, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h0000_0203;
    #1;
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL misal_req_low: got %b expected 0", bus.imem_req); end
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    #1;
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h200) begin errors++; $display("FAIL misal_addr: got req=%b addr=%h expected req=1 addr=200", bus.imem_req, bus.imem_addr); end
    @(negedge clk);
    checks++; if (bus.id_valid !== 1'b0) begin errors++; $display("FAIL misal_gap: got %b expected 0", bus.id_valid); end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'h200 + 32'(4 * k)) begin errors++; $display("FAIL misal_deliver %0d: got valid=%b pc=%h expected pc=%h", k, bus.id_valid, bus.id_pc, 32'h200 + 32'(4 * k)); end
      $display("misaligned: delivered id_pc=%h", bus.id_pc);
    end
  endtask

  task automatic test_random_latency();
    logic [31:0] exp_pc;
    logic [31:0] exp_w;
    logic [31:0] prev_addr;
    bit          prev_pending;
    int          delivered;
    exp_pc = 32'h0;
    prev_addr = 32'h0;
    prev_pending = 1'b0;
    delivered = 0;
    restart(3, 1'b1, 1'b1);
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (prev_pending) begin
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== prev_addr) begin errors++; $display("FAIL rand_req_stable c%0d: got req=%b addr=%h expected req=1 addr=%h", c, bus.imem_req, bus.imem_addr, prev_addr); end
      end
      prev_pending = bus.imem_req && !bus.imem_gnt;
      prev_addr = bus.imem_addr;
      if (bus.id_valid && bus.id_ready) begin
        exp_w = word(exp_pc);
        checks++; if (bus.id_pc !== exp_pc || bus.id_instr !== exp_w) begin errors++; $display("FAIL rand_order: got pc=%h instr=%h expected pc=%h instr=%h", bus.id_pc, bus.id_instr, exp_pc, exp_w); end
        checks++; if (bus.id_opcode !== exp_w[6:0]) begin errors++; $display("FAIL rand_opcode: got %h expected %h", bus.id_opcode, exp_w[6:0]); end
        $display("random: delivered id_pc=%h id_opcode=%h", bus.id_pc, bus.id_opcode);
        exp_pc = exp_pc + 32'd4;
        delivered++;
      end
    end
    checks++; if (delivered < 10) begin errors++; $display("FAIL rand_progress: got %0d deliveries expected at least 10", delivered); end
  endtask

  task automatic test_reset_mid();
    restart(1, 1'b0, 1'b1);
    repeat (5) @(negedge clk);
    checks++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'hC) begin errors++; $display("FAIL midrst_pre: got valid=%b pc=%h expected valid=1 pc=c", bus.id_valid, bus.id_pc); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus.id_valid !== 1'b0 || bus.imem_req !== 1'b0) begin errors++; $display("FAIL midrst_clear: got valid=%b req=%b expected both 0", bus.id_valid, bus.imem_req); end
    checks++; if (bus.imem_addr !== 32'h0 || bus.id_pc !== 32'h0) begin errors++; $display("FAIL midrst_state: got addr=%h id_pc=%h expected both 0", bus.imem_addr, bus.id_pc); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin errors++; $display("FAIL midrst_restart: got req=%b addr=%h expected req=1 addr=0", bus.imem_req, bus.imem_addr); end
    repeat (2) @(negedge clk);
    checks++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'h0) begin errors++; $display("FAIL midrst_first: got valid=%b pc=%h expected valid=1 pc=0", bus.id_valid, bus.id_pc); end
    $display("reset_mid: restarted id_pc=%h", bus.id_pc);
  endtask

  initial begin
    bus.id_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_misaligned();
    test_random_latency();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage directly upstream of the main control decoder. It owns the program counter, issues word requests to instruction memory over a request/grant/response interface, and buffers returned instructions in a small FIFO. It presents them to decode with a valid/ready handshake, and exposes `id_opcode` to drive the control decoder's `opcode` input. Branch and JAL resolution redirects the PC through a single-cycle redirect port that flushes all younger work.

## Interface
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.
- `BUF_DEPTH`, 2: instruction buffer entries and maximum in-flight plus buffered instructions; power of two, ≥2.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `imem_req` out 1: fetch request valid.
- `imem_addr` out 32: word-aligned fetch address; bits [1:0] always 0.
- `imem_gnt` in 1: request accepted this cycle.
- `imem_rvalid` in 1: response valid; responses return in order, ≥1 cycle after grant.
- `imem_rdata` in 32: instruction word.
- `redirect_valid` in 1: PC redirect from branch/JAL resolution.
- `redirect_pc` in 32: new PC; bits [1:0] ignored and treated as 0.
- `id_valid` out 1: buffer head valid to decode.
- `id_ready` in 1: decode accepts the head.
- `id_instr` out 32: head instruction.
- `id_pc` out 32: head instruction address.
- `id_opcode` out 7: `id_instr[6:0]`, feeds the control decoder.

## Operation
- State:
  - `fetch_pc`
  - `outstanding` count (0..BUF_DEPTH)
  - `drop_cnt` (0..BUF_DEPTH)
  - address FIFO of granted-request PCs
  - instruction FIFO of {pc, instr}
- Issue rule: `imem_req` = `!redirect_valid && (outstanding + count - pop) < BUF_DEPTH`, where `pop = id_valid && id_ready`.
- `imem_addr` = `fetch_pc`.
- On grant: `fetch_pc += 4` (wraps modulo 2^32), push `fetch_pc` to the address FIFO, increment `outstanding`.
- On `imem_rvalid`:
  - Pop the address FIFO and decrement `outstanding`.
  - If `drop_cnt != 0`: decrement `drop_cnt` and discard the data.
  - Otherwise: push {popped pc, `imem_rdata`} into the instruction FIFO.
- Decode side: head transfers when `id_valid && id_ready`. `id_instr`, `id_pc` and `id_opcode` hold stable while `id_valid && !id_ready`.
- Redirect (highest priority):
  - `fetch_pc <= {redirect_pc[31:2], 2'b00}`.
  - Instruction FIFO flushed.
  - `drop_cnt <= outstanding - rvalid_this_cycle`, so every in-flight response becomes stale.
  - Address FIFO entries retained for ordering only.
  - Same-cycle `imem_rvalid` is discarded.
  - A handshake in the redirect cycle completes normally.
- Back-to-back redirects: the later one wins; `drop_cnt` is recomputed each time.
- Redirect with `drop_cnt` already nonzero: the new value covers all in-flight requests and never exceeds BUF_DEPTH.
- Full buffer: no new requests are issued; in-flight responses always have a slot by construction, so there is no overflow.
- Reset values: `fetch_pc=RESET_PC`, counters 0, FIFOs empty, `imem_req=0`, `id_valid=0`, `id_instr`/`id_pc`/`id_opcode` = 0.
- Reset asserted mid-operation: all state clears immediately. Responses to pre-reset requests must not be returned by memory; memory shares `rst_n`.

## Timing
- First `imem_req` occurs in the first cycle after `rst_n` deasserts.
- Latency: grant in cycle N, `imem_rvalid` in N+1, `id_valid` in N+2 (instruction FIFO is registered, no bypass).
- Throughput: 1 instruction/cycle in steady state with 1-cycle memory and `id_ready` held high.
- Redirect in cycle R: `imem_req` is low in R; the first request to the new PC is in R+1; `id_valid` is low in R+1.
- `imem_req` and `imem_addr` are stable until grant, except across a redirect.
- No combinational path from `id_ready` to `id_valid`. The `id_ready` to `imem_req` path is allowed.

## Structure
- Shared package `riscv_pkg`:
  - opcode constants (`OPC_RTYPE`, `OPC_STORE`, `OPC_BRANCH`, `OPC_LUI`, `OPC_JAL`, `OPC_LOAD`, `OPC_OPIMM`)
  - `NOP_INSTR` = 32'h0000_0013
  - `XLEN` = 32
- Sub-module `fetch_fifo`: parameterised width/depth synchronous FIFO with flush, count output, and async active-low reset. Instantiated twice: address FIFO (32 bits) and instruction FIFO (64 bits).

## Test plan
- Reset release, 1-cycle memory, `id_ready=1` → addresses 0x0, 0x4, 0x8… on consecutive cycles; `id_pc` 0x0 first `id_valid` at cycle 2, then one instruction/cycle.
- `id_ready=0` for 5 cycles → at most 2 grants, `id_valid` held with `id_pc`=0x0 stable, no request while full; release → 0x0, 0x4 delivered in order.
- Redirect to 0x100 with 2 requests outstanding → both responses dropped, next delivered `id_pc`=0x100, no stale instruction reaches decode.
- `redirect_pc`=0x203 → `imem_addr`=0x200.
- Memory latency 3 cycles with random grant stalls → in-order delivery, `id_pc` strictly +4, `id_opcode == id_instr[6:0]`.
- `rst_n` asserted mid-stream → `id_valid`, `imem_req` 0 immediately; after release, fetch restarts at `RESET_PC`.
